// File: rtl/mic_pkg.sv
// Shared types and default sizing for the PDM microphone record/playback path.
package mic_pkg;

  localparam int MCLK_HALF_D = 25;
  localparam int DEC_D       = 64;
  localparam int ADDR_W_D    = 14;
  localparam int SAMPLE_W_D  = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2
  } state_t;

endpackage

// File: rtl/mic_rec_ctrl_if.sv
// Sample RAM port: the controller is master, the single-port RAM is slave.
interface mic_rec_ctrl_if
  import mic_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_D,
  parameter int SAMPLE_W = SAMPLE_W_D
);

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [SAMPLE_W-1:0] mem_wdata;
  logic [SAMPLE_W-1:0] mem_rdata;

  modport master (
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mic_clk_gen.sv
// Free-running microphone bit clock divider; tick marks the first high
// cycle of each mic_clk period.
module mic_clk_gen
  import mic_pkg::*;
#(
  parameter int MCLK_HALF = MCLK_HALF_D
) (
  input  logic clk,
  input  logic reset,
  output logic mic_clk,
  output logic tick
);

  localparam int CW = $clog2(MCLK_HALF + 1);
  localparam logic [CW-1:0] TC = CW'(MCLK_HALF - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt     <= '0;
      mic_clk <= 1'b0;
      tick    <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (cnt == TC) begin
        cnt     <= '0;
        mic_clk <= ~mic_clk;
        tick    <= ~mic_clk;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/mic_rec_ctrl.sv
// PDM record/playback sequencer sharing one sample RAM.
// Define MIC_PLAY_LOOP_EN for continuous looped playback.
module mic_rec_ctrl
  import mic_pkg::*;
#(
  parameter int MCLK_HALF = MCLK_HALF_D,
  parameter int DEC       = DEC_D,
  parameter int ADDR_W    = ADDR_W_D,
  parameter int SAMPLE_W  = SAMPLE_W_D
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mic_data,
  output logic                mic_clk,
  output logic                mic_lr,
  input  logic                rec_req,
  input  logic                play_req,
  input  logic                stop_req,
  mic_rec_ctrl_if.master      mem,
  output logic [SAMPLE_W-1:0] pcm_out,
  output logic                pcm_valid,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W:0]     length
);

  localparam int BW = $clog2(DEC + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DEC - 1);
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

`ifdef MIC_PLAY_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  state_t              state;
  state_t              state_n;
  logic                tick;
  logic                go_idle;
  logic                bound;
  logic                last;
  logic [BW-1:0]       bitcnt;
  logic [SAMPLE_W-1:0] acc;
  logic [SAMPLE_W-1:0] wdata_q;
  logic [ADDR_W:0]     wptr;
  logic [ADDR_W:0]     rptr;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;

  mic_clk_gen #(
    .MCLK_HALF(MCLK_HALF)
  ) u_clk_gen (
    .clk    (clk),
    .reset  (reset),
    .mic_clk(mic_clk),
    .tick   (tick)
  );

  assign mic_lr        = 1'b0;
  assign busy          = (state != IDLE);
  assign bound         = tick && (bitcnt == LAST_BIT);
  assign last          = ((rptr + ONE) == length);
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    go_idle = 1'b0;
    unique case (state)
      IDLE: begin
        if (rec_req)       state_n = RECORD;
        else if (play_req) state_n = PLAY;
      end
      RECORD: go_idle = stop_req || (we_q && wptr == DEPTH);
      PLAY: begin
        go_idle = stop_req || (length == '0) ||
                  (!LOOP && bound && last);
      end
      default: state_n = IDLE;
    endcase
    if (go_idle) state_n = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      pcm_out   <= '0;
      pcm_valid <= 1'b0;
      done      <= 1'b0;
      length    <= '0;
      bitcnt    <= '0;
      acc       <= '0;
      wptr      <= '0;
      rptr      <= '0;
    end else begin
      we_q      <= 1'b0;
      pcm_valid <= 1'b0;
      done      <= go_idle;
      unique case (state)
        RECORD: begin
          // a stop in the last-bit cycle drops the partial sample
          if (go_idle) begin
            length <= wptr;
          end else if (tick) begin
            if (bitcnt == LAST_BIT) begin
              we_q    <= 1'b1;
              addr_q  <= wptr[ADDR_W-1:0];
              wdata_q <= acc + SAMPLE_W'(mic_data);
              wptr    <= wptr + ONE;
              acc     <= '0;
              bitcnt  <= '0;
            end else begin
              acc    <= acc + SAMPLE_W'(mic_data);
              bitcnt <= bitcnt + BW'(1);
            end
          end
        end
        PLAY: begin
          if (!stop_req && length != '0 && tick) begin
            if (bitcnt == LAST_BIT) begin
              pcm_out   <= mem.mem_rdata;
              pcm_valid <= 1'b1;
              bitcnt    <= '0;
              if (last) begin
                rptr   <= '0;
                addr_q <= '0;
              end else begin
                rptr   <= rptr + ONE;
                addr_q <= rptr[ADDR_W-1:0] + ADDR_W'(1);
              end
            end else begin
              bitcnt <= bitcnt + BW'(1);
            end
          end
        end
        default: begin
          bitcnt <= '0;
          acc    <= '0;
          wptr   <= '0;
          rptr   <= '0;
          addr_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mic_rec_ctrl.sv
// Bench for mic_rec_ctrl: recording scenario table, playback and reset
// sequences, with write/pcm scoreboards.
module tb_mic_rec_ctrl;

  localparam int MH  = 2;
  localparam int DEC = 8;
  localparam int AW  = 3;
  localparam int SW  = 4;
  localparam int GAP = DEC * 2 * MH;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          mic_data = 1'b0;
  logic          rec_req = 1'b0;
  logic          play_req = 1'b0;
  logic          stop_req = 1'b0;
  logic          mic_clk;
  logic          mic_lr;
  logic [SW-1:0] pcm_out;
  logic          pcm_valid;
  logic          busy;
  logic          done;
  logic [AW:0]   length;

  mic_rec_ctrl_if #(.ADDR_W(AW), .SAMPLE_W(SW)) mem ();

  mic_rec_ctrl #(
    .MCLK_HALF(MH),
    .DEC      (DEC),
    .ADDR_W   (AW),
    .SAMPLE_W (SW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .mic_data (mic_data),
    .mic_clk  (mic_clk),
    .mic_lr   (mic_lr),
    .rec_req  (rec_req),
    .play_req (play_req),
    .stop_req (stop_req),
    .mem      (mem),
    .pcm_out  (pcm_out),
    .pcm_valid(pcm_valid),
    .busy     (busy),
    .done     (done),
    .length   (length)
  );

  logic [SW-1:0] ram [2**AW];

  initial begin
    for (int i = 0; i < 2**AW; i++) ram[i] = '0;
    mem.mem_rdata = '0;
  end

  always @(posedge clk) begin
    if (mem.mem_we) ram[mem.mem_addr] <= mem.mem_wdata;
    mem.mem_rdata <= ram[mem.mem_addr];
  end

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t wq[$];
  int  pq[$];
  int  pat = 0;
  bit  wr_first = 1'b1;
  bit  pc_first = 1'b1;
  int  last_wr = 0;
  int  last_pc = 0;
  int  wr_seen = 0;
  int  pc_seen = 0;
  wr_t wexp;
  int  pexp;

  always @(posedge mic_clk) begin
    #1;
    mic_data = (pat == 0) ? 1'b1 : ~mic_data;
  end

  always @(negedge clk) begin
    if (mem.mem_we) begin
      wr_seen++;
      chk("we_in_record", busy, 1);
      if (wq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_write: addr=%0d data=%0d", mem.mem_addr, mem.mem_wdata);
      end else begin
        wexp = wq.pop_front();
        chk("waddr", mem.mem_addr, wexp.addr);
        chk("wdata", mem.mem_wdata, wexp.data);
        if (!wr_first) chk("wgap", cyc - last_wr, GAP);
        wr_first = 1'b0;
        last_wr  = cyc;
      end
    end
    if (pcm_valid) begin
      pc_seen++;
      if (pq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_pcm: pcm_out=%0d", pcm_out);
      end else begin
        pexp = pq.pop_front();
        chk("pcm_out", pcm_out, pexp);
        if (!pc_first) chk("pgap", cyc - last_pc, GAP);
        pc_first = 1'b0;
        last_pc  = cyc;
      end
    end
  end

  task automatic cyc_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while (done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(name, done, 1);
  endtask

  task automatic wait_wr(input int n, input int budget);
    int k = 0;
    while (wr_seen < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("writes_seen", wr_seen, n);
  endtask

  task automatic pulse_stop();
    stop_req = 1'b1;
    @(negedge clk);
    stop_req = 1'b0;
  endtask

  typedef struct {
    int pat;
    int both;
    int nstop;
    int wd;
    int nwr;
    int len;
  } row_t;

  row_t rows[3];
  int   mcp[8];

  initial begin
    rows[0] = '{pat: 1, both: 0, nstop: 2, wd: 4, nwr: 2, len: 2};
    rows[1] = '{pat: 1, both: 1, nstop: 0, wd: 4, nwr: 8, len: 8};
    rows[2] = '{pat: 0, both: 0, nstop: 3, wd: 8, nwr: 3, len: 3};
    mcp = '{0, 1, 1, 0, 0, 1, 1, 0};

    cyc_n(3);
    chk("rst_mic_clk", mic_clk, 0);
    chk("rst_mic_lr", mic_lr, 0);
    chk("rst_we", mem.mem_we, 0);
    chk("rst_addr", mem.mem_addr, 0);
    chk("rst_wdata", mem.mem_wdata, 0);
    chk("rst_pcm", pcm_out, 0);
    chk("rst_pvalid", pcm_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_length", length, 0);
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("mic_clk_c%0d", k + 1), mic_clk, mcp[k]);
    end

    play_req = 1'b1;
    @(negedge clk);
    play_req = 1'b0;
    chk("p0_busy", busy, 1);
    @(negedge clk);
    chk("p0_done", done, 1);
    chk("p0_idle", busy, 0);
    @(negedge clk);
    chk("p0_done_off", done, 0);

    for (int r = 0; r < 3; r++) begin
      pat = rows[r].pat;
      cyc_n(8);
      for (int k = 0; k < rows[r].nwr; k++) wq.push_back('{k, rows[r].wd});
      wr_first = 1'b1;
      wr_seen  = 0;
      rec_req  = 1'b1;
      play_req = (rows[r].both != 0);
      @(negedge clk);
      rec_req  = 1'b0;
      play_req = 1'b0;
      chk("rec_busy", busy, 1);
      if (rows[r].nstop > 0) begin
        wait_wr(rows[r].nstop, GAP * (rows[r].nstop + 2));
        cyc_n(5);
        pulse_stop();
        chk("stop_done", done, 1);
        chk("stop_idle", busy, 0);
      end else begin
        wait_done("full_done", GAP * 10);
        chk("full_idle", busy, 0);
      end
      @(negedge clk);
      chk("done_pulse", done, 0);
      chk("length", length, rows[r].len);
      chk("wq_empty", wq.size(), 0);
      cyc_n(GAP * 2);
      chk("writes_total", wr_seen, rows[r].nwr);
      wq.delete();
    end

    pc_first = 1'b1;
    pc_seen  = 0;
`ifdef MIC_PLAY_LOOP_EN
    for (int k = 0; k < 6; k++) pq.push_back(8);
`else
    for (int k = 0; k < 3; k++) pq.push_back(8);
`endif
    play_req = 1'b1;
    @(negedge clk);
    play_req = 1'b0;
    chk("play_busy", busy, 1);
`ifdef MIC_PLAY_LOOP_EN
    begin
      int k = 0;
      while (pc_seen < 6 && k < GAP * 8) begin
        @(negedge clk);
        k++;
      end
    end
    chk("loop_pulses", pc_seen, 6);
    cyc_n(3);
    chk("loop_busy", busy, 1);
    pulse_stop();
    chk("loop_stop_done", done, 1);
`else
    wait_done("play_done", GAP * 5);
    @(negedge clk);
    chk("play_pulses", pc_seen, 3);
    chk("play_idle", busy, 0);
`endif
    cyc_n(GAP * 2);
    chk("pq_empty", pq.size(), 0);
    pq.delete();

    pat = 0;
    cyc_n(4);
    wq.push_back('{0, 8});
    wr_first = 1'b1;
    wr_seen  = 0;
    rec_req  = 1'b1;
    @(negedge clk);
    rec_req = 1'b0;
    wait_wr(1, GAP * 3);
    cyc_n(10);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_length", length, 0);
    chk("mid_rst_we", mem.mem_we, 0);
    chk("mid_rst_done", done, 0);
    cyc_n(2);
    reset = 1'b1;
    cyc_n(GAP + 8);
    chk("mid_rst_nowrite", wr_seen, 1);
    chk("mid_rst_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

endmodule
